// File: rtl/seq_det_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_arbiter
// Function : Round-robin sharing of one moore_1010 detector among N_REQ
//            serial requesters; reports per-frame match counts.
// Revision : 1.0  initial release
// ============================================================================
module seq_det_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] valid,
    input  logic [N_REQ-1:0] bit_in,
    input  logic [N_REQ-1:0] last,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             det_rst,
    output logic             det_x,
    input  logic             det_y,
    output logic             done,
    output logic [ID_W-1:0]  done_id,
    output logic [CNT_W-1:0] match_cnt,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ID_W-1:0]  C_ID_LAST = ID_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] C_ONE     = N_REQ'(1);

    state_t           r_state;
    state_t           w_next;
    logic [ID_W-1:0]  r_gid;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_win;
    logic [ID_W-1:0]  w_cand;
    logic             w_found;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_first;
    logic             w_bit_valid;
    logic             w_bit_last;

    assign w_bit_valid = valid[r_gid];
    assign w_bit_last  = last[r_gid];
    assign w_cnt_inc   = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // Search upward from the last winner, wrapping at N_REQ-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = r_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = (w_cand == C_ID_LAST) ? '0 : w_cand + ID_W'(1);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        busy    = (r_state != S_IDLE);
        det_rst = 1'b1;
        det_x   = 1'b0;
        done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_next = S_CLR;
            end
            S_CLR: begin
                w_next = S_STREAM;
            end
            S_STREAM: begin
                det_rst = 1'b0;
                det_x   = bit_in[r_gid];
                if (!w_bit_valid)    w_next = S_IDLE;
                else if (w_bit_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                det_rst = 1'b0;
                w_next  = S_REPORT;
            end
            S_REPORT: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gid     <= '0;
            r_ptr     <= C_ID_LAST;
            r_cnt     <= '0;
            r_first   <= 1'b0;
            grant     <= '0;
            done_id   <= '0;
            match_cnt <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gid <= w_win;
                        r_ptr <= w_win;
                        r_cnt <= '0;
                        grant <= C_ONE << w_win;
                    end
                end
                S_CLR: begin
                    r_first <= 1'b1;
                end
                S_STREAM: begin
                    r_first <= 1'b0;
                    if (!w_bit_valid) begin
                        err   <= 1'b1;
                        grant <= '0;
                    end else begin
                        // y on the first stream cycle still reflects the cleared detector
                        if (det_y && !r_first) r_cnt <= w_cnt_inc;
                        if (w_bit_last) grant <= '0;
                    end
                end
                S_DRAIN: begin
                    done_id   <= r_gid;
                    match_cnt <= det_y ? w_cnt_inc : r_cnt;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_det_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_arbiter
// Function : Self-checking bench for seq_det_arbiter with a behavioural
//            1010 detector and round-robin reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_det_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0, valid = '0, bit_in = '0, last = '0;

    logic [N-1:0] grant, grant_s;
    logic         busy, det_rst, det_x, det_y, done, err;
    logic         busy_s, det_rst_s, det_x_s, det_y_s, done_s, err_s;
    logic [1:0]   done_id, done_id_s;
    logic [W-1:0] match_cnt;
    logic [1:0]   match_cnt_s;

    logic [3:0]   hist = '0, hist_s = '0;

    int total = 0;
    int bad = 0;
    int ptr = N - 1;
    int last_cnt = 0;

    seq_det_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .valid(valid), .bit_in(bit_in), .last(last),
        .grant(grant), .busy(busy), .det_rst(det_rst), .det_x(det_x), .det_y(det_y),
        .done(done), .done_id(done_id), .match_cnt(match_cnt), .err(err)
    );

    seq_det_arbiter #(.N_REQ(N), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .req(req), .valid(valid), .bit_in(bit_in), .last(last),
        .grant(grant_s), .busy(busy_s), .det_rst(det_rst_s), .det_x(det_x_s), .det_y(det_y_s),
        .done(done_s), .done_id(done_id_s), .match_cnt(match_cnt_s), .err(err_s)
    );

    always #5 clk = ~clk;

    // Behavioural detector: y is high once the last four bits seen were 1010.
    assign det_y   = (hist == 4'b1010);
    assign det_y_s = (hist_s == 4'b1010);
    always @(posedge clk) begin
        hist   <= det_rst   ? 4'b0000 : {hist[2:0], det_x};
        hist_s <= det_rst_s ? 4'b0000 : {hist_s[2:0], det_x_s};
    end

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 1; i <= N; i++) begin
            int k = (p + i) % N;
            if (r[k]) return k;
        end
        return 0;
    endfunction

    function automatic int ref_count(input logic [63:0] b, input int len, input int maxv);
        int n = 0;
        for (int i = 0; i + 4 <= len; i++)
            if (b[len-1-i -: 4] == 4'b1010) n++;
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        valid  = N'($urandom);
        bit_in = N'($urandom);
        last   = N'($urandom);
    endtask

    task automatic do_reset();
        valid = '0; bit_in = '0; last = '0; req = '0;
        #2 rst = 1'b0;
        step(); step();
        #2 rst = 1'b1;
        ptr = N - 1;
        last_cnt = 0;
        step();
    endtask

    // Waits for the grant, streams one frame MSB-first, checks drain and report.
    task automatic do_frame(input logic [63:0] bits, input int len, output int waits);
        int exp_id, e8, e2;
        logic b;
        exp_id = rr_pick(req, ptr);
        waits = 0;
        while (grant == '0 && waits < 20) begin
            step();
            waits++;
        end
        total++;
        if (grant !== (N'(1) << exp_id)) begin
            bad++;
            $display("FAIL grant: got %b want %b (waited %0d)", grant, N'(1) << exp_id, waits);
            req = '0;
            return;
        end
        ptr = exp_id;
        req[exp_id] = 1'b0;
        total++;
        if ({busy, det_rst, done, err} !== 4'b1100) begin
            bad++;
            $display("FAIL clr_state: busy/det_rst/done/err got %b want 1100", {busy, det_rst, done, err});
        end
        for (int i = 0; i < len; i++) begin
            step();
            b = bits[len-1-i];
            noise();
            valid[exp_id]  = 1'b1;
            bit_in[exp_id] = b;
            last[exp_id]   = (i == len - 1);
            #1;
            total++;
            if ({det_x, det_rst, done, err, grant_s == grant} !== {b, 4'b0001}) begin
                bad++;
                $display("FAIL stream bit %0d: det_x/det_rst/done/err/same got %b want %b",
                         i, {det_x, det_rst, done, err, grant_s == grant}, {b, 4'b0001});
            end
        end
        step();
        valid = '0; bit_in = '0; last = '0;
        total++;
        if ({grant, det_x, det_rst, done} !== {N'(0), 3'b000}) begin
            bad++;
            $display("FAIL drain: grant/det_x/det_rst/done got %b want %b",
                     {grant, det_x, det_rst, done}, {N'(0), 3'b000});
        end
        step();
        e8 = ref_count(bits, len, 255);
        e2 = ref_count(bits, len, 3);
        total++;
        if ({done, done_s, det_rst, done_id, done_id_s} !== {3'b111, 2'(exp_id), 2'(exp_id)}) begin
            bad++;
            $display("FAIL report: done/done_s/det_rst/done_id/done_id_s got %b want %b",
                     {done, done_s, det_rst, done_id, done_id_s}, {3'b111, 2'(exp_id), 2'(exp_id)});
        end
        total++;
        if (match_cnt !== W'(e8) || match_cnt_s !== 2'(e2)) begin
            bad++;
            $display("FAIL match_cnt: got %0d/%0d want %0d/%0d", match_cnt, match_cnt_s, e8, e2);
        end
        last_cnt = e8;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({grant, det_rst, det_x, done, err, busy} !== {N'(0), 5'b10000}) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want %b", {grant, det_rst, det_x, done, err, busy}, {N'(0), 5'b10000});
        end
        total++;
        if (done_id !== 2'd0 || match_cnt !== W'(0)) begin
            bad++;
            $display("FAIL reset_data: done_id=%0d match_cnt=%0d want 0 0", done_id, match_cnt);
        end
        step(); step();
        #2 rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        int w;
        req = 4'b0001;
        do_frame(64'b101010, 6, w);
    endtask

    task automatic test_round_robin();
        int w;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            req = 4'b1111;
            for (int f = 0; f < N; f++) begin
                do_frame(64'b1010, 4, w);
                total++;
                if (ptr !== f) begin
                    bad++;
                    $display("FAIL rr_order: served %0d want %0d", ptr, f);
                end
                if (f > 0) begin
                    total++;
                    if (w !== 2) begin
                        bad++;
                        $display("FAIL back_to_back: gap %0d want 2", w);
                    end
                end
            end
            step();
        end
    endtask

    task automatic test_flush();
        int w;
        req = 4'b0010;
        do_frame(64'b1010, 4, w);
        req = 4'b0100;
        do_frame(64'b10, 2, w);
        step();
    endtask

    task automatic test_abort();
        int exp_id, w;
        do_reset();
        req = 4'b1100;
        exp_id = rr_pick(req, ptr);
        w = 0;
        while (grant == '0 && w < 20) begin step(); w++; end
        total++;
        if (grant !== (N'(1) << exp_id)) begin
            bad++;
            $display("FAIL abort_grant: got %b want %b", grant, N'(1) << exp_id);
        end
        ptr = exp_id;
        req[exp_id] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            noise();
            valid[exp_id] = 1'b1;
            last[exp_id]  = 1'b0;
        end
        step();
        noise();
        valid[exp_id] = 1'b0;
        step();
        valid = '0; bit_in = '0; last = '0;
        total++;
        if ({err, done, busy, det_rst, grant} !== {4'b1001, N'(0)}) begin
            bad++;
            $display("FAIL abort: err/done/busy/det_rst/grant got %b want %b",
                     {err, done, busy, det_rst, grant}, {4'b1001, N'(0)});
        end
        total++;
        if (match_cnt !== W'(last_cnt)) begin
            bad++;
            $display("FAIL abort_hold: match_cnt got %0d want %0d", match_cnt, last_cnt);
        end
        step();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL abort_pulse: err got %b want 0", err);
        end
        do_frame(64'b1010, 4, w);
        step();
    endtask

    task automatic test_saturate();
        int w;
        req = 4'b0100;
        do_frame(64'b101010101010, 12, w);
        step();
    endtask

    task automatic test_reset_mid();
        int exp_id, w;
        req = 4'b0011;
        exp_id = rr_pick(req, ptr);
        w = 0;
        while (grant == '0 && w < 20) begin step(); w++; end
        for (int i = 0; i < 2; i++) begin
            step();
            valid[exp_id] = 1'b1;
            bit_in[exp_id] = ~i[0];
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({grant, det_rst, busy, det_x, done, err} !== {N'(0), 5'b10000}) begin
            bad++;
            $display("FAIL midrst: got %b want %b", {grant, det_rst, busy, det_x, done, err}, {N'(0), 5'b10000});
        end
        valid = '0; bit_in = '0; last = '0;
        req = 4'b0011;
        step(); step();
        total++;
        if ({done, err, done_s, err_s} !== 4'b0000 || match_cnt !== W'(0) || match_cnt_s !== 2'd0) begin
            bad++;
            $display("FAIL midrst_hold: done/err=%b match_cnt=%0d/%0d want 0000 0/0",
                     {done, err, done_s, err_s}, match_cnt, match_cnt_s);
        end
        #2 rst = 1'b1;
        ptr = N - 1;
        last_cnt = 0;
        do_frame(64'b1010, 4, w);
        req = '0;
        step(); step();
    endtask

    task automatic test_random();
        int w, len, guard;
        logic [63:0] bits;
        for (int it = 0; it < 12; it++) begin
            req = req | N'($urandom_range(1, 15));
            guard = 0;
            while (req != '0 && guard < 8) begin
                len  = $urandom_range(1, 24);
                bits = {$urandom, $urandom};
                do_frame(bits, len, w);
                if (($urandom & 3) == 0) req = req | N'($urandom);
                guard++;
            end
        end
        req = '0;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_flush();
        test_abort();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
